// File: rtl/cnt_pkg.sv
// Shared definitions for the cascadable up-counter: slice geometry, the
// priority-decoded operation encoding and the terminal-count compare.
package cnt_pkg;

    // Every counter is built from slices of this many bits.
    localparam int SLICE_W = 4;

    // Widest counter the terminal-count helper can compare.
    localparam int TERM_CMP_W = 64;

    // One operation per clock edge, already resolved by priority.
    typedef enum logic [2:0] {
        OP_RST,
        OP_CLR,
        OP_LOAD,
        OP_INC,
        OP_HOLD
    } op_e;

    // True when the current count sits on the terminal value. Callers
    // zero-extend both operands to TERM_CMP_W bits.
    function automatic logic terminal_hit(
        input logic [TERM_CMP_W-1:0] cnt,
        input logic [TERM_CMP_W-1:0] term
    );
        return (cnt == term);
    endfunction

    // Resolve the control inputs into a single operation, highest
    // priority first: reset, clear, load, increment, hold.
    function automatic op_e decode_op(
        input logic rst,
        input logic clr,
        input logic load,
        input logic inc_en
    );
        if (rst) begin
            return OP_RST;
        end else if (clr) begin
            return OP_CLR;
        end else if (load) begin
            return OP_LOAD;
        end else if (inc_en) begin
            return OP_INC;
        end
        return OP_HOLD;
    endfunction

endpackage : cnt_pkg

// File: rtl/cnt_slice4.sv
// One 4-bit slice of the up-counter. It applies the operation chosen by the
// top level; on OP_INC it only advances when its carry input is set, i.e.
// when every lower slice is at its maximum. The carry output is purely
// combinational so the chain resolves within one cycle.
module cnt_slice4
    import cnt_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [SLICE_W-1:0] load_data,
    input  op_e                op,
    input  logic               carry_in,
    output logic [SLICE_W-1:0] value,
    output logic               carry_out
);

    logic [SLICE_W-1:0] value_d;
    logic [SLICE_W-1:0] value_q;

    // Next slice value from the resolved operation.
    always_comb begin
        // NOTE: default assignment first so no path leaves value_d unassigned (no latch).
        value_d = value_q;
        case (op)
            OP_RST,
            OP_CLR:  value_d = '0;
            OP_LOAD: value_d = load_data;
            OP_INC: begin
                if (carry_in) begin
                    value_d = value_q + SLICE_W'(1);
                end
            end
            OP_HOLD: value_d = value_q;
            default: value_d = value_q;
        endcase
    end

    // Slice state register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every slice sampling pre-edge values.
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value     = value_q;
    assign carry_out = carry_in & (value_q == '1);

endmodule : cnt_slice4

// File: rtl/sync_up_counter_casc.sv
// Cascadable synchronous loadable binary up-counter. The count is held in
// WIDTH/4 chained slices; this level resolves control priority, overrides
// the slices back to zero when the terminal count is incremented, and
// produces the ripple carry out (rco) and the registered wrap pulse.
//
// Limits: WIDTH is a multiple of 4 between 4 and 64; 0 < TERM. Binary
// cascading of several instances via rco -> ent only works with
// TERM = 2**WIDTH-1.
module sync_up_counter_casc
    import cnt_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TERM  = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enp,
    input  logic             ent,
    output logic [WIDTH-1:0] cnt,
    output logic             rco,
    output logic             wrap
);

    localparam int unsigned NUM_SLICES = WIDTH / SLICE_W;

    // With a full-range terminal count the carry out of the whole chain is
    // already the "increment at terminal" condition, so no separate compare
    // is needed on that path.
    localparam logic TERM_IS_MAX = (TERM == {WIDTH{1'b1}});

    // Elaboration-time parameter sanity.
    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W || WIDTH > TERM_CMP_W) begin : g_bad_width
        $error("sync_up_counter_casc: WIDTH must be a multiple of 4 in 4..64");
    end
    if (TERM == '0) begin : g_bad_term
        $error("sync_up_counter_casc: TERM must be non-zero");
    end

    op_e                 op;
    op_e                 slice_op;
    logic                inc_en;
    logic                term_hit;
    logic                wrap_hit;
    logic                wrap_d;
    logic                wrap_q;
    logic [WIDTH-1:0]    cnt_q;
    logic [NUM_SLICES:0] carry;

    assign inc_en   = enp & ent;
    assign term_hit = terminal_hit(TERM_CMP_W'(cnt_q), TERM_CMP_W'(TERM));

    // Priority decode of the control inputs into one operation.
    always_comb begin
        op = decode_op(rst, clr, load, inc_en);
    end

    // Terminal-count handling: an increment at TERM clears every slice and
    // arms the wrap pulse; all other operations pass straight through.
    always_comb begin
        wrap_hit = TERM_IS_MAX ? carry[NUM_SLICES] : (inc_en & term_hit);
        wrap_d   = (op == OP_INC) && wrap_hit;
        slice_op = wrap_d ? OP_CLR : op;
    end

    // Carry chain seed: slice 0 advances on every qualified increment.
    assign carry[0] = inc_en;

    for (genvar g = 0; g < NUM_SLICES; g++) begin : g_slice
        cnt_slice4 u_slice (
            .clk       (clk),
            .rst       (rst),
            .load_data (load_val[g*SLICE_W +: SLICE_W]),
            .op        (slice_op),
            .carry_in  (carry[g]),
            .value     (cnt_q[g*SLICE_W +: SLICE_W]),
            .carry_out (carry[g+1])
        );
    end

    // Wrap pulse register: high for exactly the cycle after TERM -> 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = wrap_q;
    assign rco  = ent & term_hit;

endmodule : sync_up_counter_casc

// File: tb/tb_sync_up_counter_casc.sv
// Self-checking bench for sync_up_counter_casc. Three configurations run
// side by side: an 8-bit full-range counter (a), an 8-bit modulo-10
// counter (b) sharing a's controls, and two 4-bit counters cascaded via
// rco -> ent (c0/c1). Reference models track each as plain integers.
module tb_sync_up_counter_casc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared controls for instances a and b
    logic       rst, clr, load, enp, ent;
    logic [7:0] load_val;
    logic [7:0] a_cnt, b_cnt;
    logic       a_rco, a_wrap, b_rco, b_wrap;

    // Cascade controls/outputs
    logic       c_enp, c_ent0, c_clr, c_load;
    logic [3:0] c_lv;
    logic [3:0] c0_cnt, c1_cnt;
    logic       c0_rco, c0_wrap, c1_rco, c1_wrap;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int ma_cnt = 0, mb_cnt = 0, mc_tot = 0;
    bit ma_wrap = 0, mb_wrap = 0, mc_w0 = 0, mc_w1 = 0;

    sync_up_counter_casc #(.WIDTH(8), .TERM(8'hFF)) u_a (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .enp(enp), .ent(ent), .cnt(a_cnt), .rco(a_rco), .wrap(a_wrap)
    );

    sync_up_counter_casc #(.WIDTH(8), .TERM(8'd9)) u_b (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .enp(enp), .ent(ent), .cnt(b_cnt), .rco(b_rco), .wrap(b_wrap)
    );

    sync_up_counter_casc #(.WIDTH(4)) u_c0 (
        .clk(clk), .rst(rst), .clr(c_clr), .load(c_load), .load_val(c_lv),
        .enp(c_enp), .ent(c_ent0), .cnt(c0_cnt), .rco(c0_rco), .wrap(c0_wrap)
    );

    sync_up_counter_casc #(.WIDTH(4)) u_c1 (
        .clk(clk), .rst(rst), .clr(c_clr), .load(c_load), .load_val(c_lv),
        .enp(c_enp), .ent(c0_rco), .cnt(c1_cnt), .rco(c1_rco), .wrap(c1_wrap)
    );

    // Behavioural next-state for a single 8-bit counter with terminal 'term'.
    function automatic void model_next(input int cur, input int term,
                                       output int nxt, output bit w);
        w = 1'b0;
        if (rst || clr)       nxt = 0;
        else if (load)        nxt = int'(load_val);
        else if (enp && ent) begin
            if (cur == term) begin
                nxt = 0;
                w   = 1'b1;
            end else begin
                nxt = (cur + 1) % 256;
            end
        end else              nxt = cur;
    endfunction

    // Advance one clock: models take the pre-edge inputs, outputs are
    // sampled 1 time unit after the rising edge.
    task automatic step();
        int na, nb, nc;
        bit wa, wb, w0, w1;
        model_next(ma_cnt, 255, na, wa);
        model_next(mb_cnt, 9, nb, wb);
        w0 = 1'b0;
        w1 = 1'b0;
        if (rst || c_clr) begin
            nc = 0;
        end else if (c_enp && c_ent0) begin
            w0 = (mc_tot % 16 == 15);
            w1 = (mc_tot == 255);
            nc = (mc_tot + 1) % 256;
        end else begin
            nc = mc_tot;
        end
        @(posedge clk);
        #1;
        ma_cnt = na; ma_wrap = wa;
        mb_cnt = nb; mb_wrap = wb;
        mc_tot = nc; mc_w0 = w0; mc_w1 = w1;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; load = 1'b1; load_val = 8'hA5;
        enp = 1'b1; ent = 1'b1;
        c_enp = 1'b1; c_ent0 = 1'b1; c_clr = 1'b0; c_load = 1'b0; c_lv = 4'h0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if ({a_cnt, a_wrap, a_rco, b_cnt, b_wrap, b_rco} !== 20'h0) begin
                n_fail++;
                $display("FAIL reset_ab[%0d]: a cnt=%h wrap=%b rco=%b b cnt=%h wrap=%b rco=%b, want all 0",
                         i, a_cnt, a_wrap, a_rco, b_cnt, b_wrap, b_rco);
            end
            n_checks++;
            if ({c1_cnt, c0_cnt, c0_wrap, c1_wrap, c0_rco, c1_rco} !== 12'h0) begin
                n_fail++;
                $display("FAIL reset_casc[%0d]: c1=%h c0=%h wraps=%b%b rcos=%b%b, want all 0",
                         i, c1_cnt, c0_cnt, c1_wrap, c0_wrap, c1_rco, c0_rco);
            end
        end
        rst = 1'b0; load = 1'b0; enp = 1'b0; ent = 1'b0;
        c_enp = 1'b0; c_ent0 = 1'b0;
    endtask

    task automatic test_count_wrap();
        logic [7:0] exp_seq [5] = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01};
        load = 1'b1; load_val = 8'hFD;
        step();
        n_checks++;
        if (a_cnt !== exp_seq[0]) begin
            n_fail++;
            $display("FAIL count_load: got cnt=%h want %h", a_cnt, exp_seq[0]);
        end
        load = 1'b0; enp = 1'b1; ent = 1'b1;
        for (int i = 1; i < 5; i++) begin
            step();
            n_checks++;
            if ({a_cnt, a_rco, a_wrap} !== {exp_seq[i], (exp_seq[i] == 8'hFF), (i == 3)}) begin
                n_fail++;
                $display("FAIL count_wrap[%0d]: got cnt=%h rco=%b wrap=%b want cnt=%h rco=%b wrap=%b",
                         i, a_cnt, a_rco, a_wrap, exp_seq[i], (exp_seq[i] == 8'hFF), (i == 3));
            end
            // b was loaded above its terminal: natural 8-bit rollover, never a wrap pulse
            n_checks++;
            if ({b_cnt, b_wrap} !== {exp_seq[i], 1'b0}) begin
                n_fail++;
                $display("FAIL count_over_term[%0d]: got cnt=%h wrap=%b want cnt=%h wrap=0",
                         i, b_cnt, b_wrap, exp_seq[i]);
            end
        end
        enp = 1'b0; ent = 1'b0;
    endtask

    task automatic test_enable_split();
        load = 1'b1; load_val = 8'hFF;
        step();
        load = 1'b0; enp = 1'b0; ent = 1'b1;
        step();
        n_checks++;
        if ({a_cnt, a_rco, b_cnt, b_rco} !== {8'hFF, 1'b1, 8'hFF, 1'b0}) begin
            n_fail++;
            $display("FAIL enp_low: a cnt=%h rco=%b b cnt=%h rco=%b want FF/1 FF/0",
                     a_cnt, a_rco, b_cnt, b_rco);
        end
        ent = 1'b0;
        #1;
        n_checks++;
        if (a_rco !== 1'b0) begin
            n_fail++;
            $display("FAIL ent_gates_rco: got rco=%b want 0", a_rco);
        end
        step();
        n_checks++;
        if ({a_cnt, a_rco, a_wrap} !== {8'hFF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL ent_low_hold: got cnt=%h rco=%b wrap=%b want FF/0/0", a_cnt, a_rco, a_wrap);
        end
    endtask

    task automatic test_priority();
        load = 1'b1; load_val = 8'h10;
        step();
        load_val = 8'h3C; enp = 1'b1; ent = 1'b1;
        step();
        n_checks++;
        if ({a_cnt, a_wrap} !== {8'h3C, 1'b0}) begin
            n_fail++;
            $display("FAIL load_over_inc: got cnt=%h wrap=%b want 3C/0", a_cnt, a_wrap);
        end
        clr = 1'b1;
        step();
        n_checks++;
        if ({a_cnt, a_wrap, b_cnt} !== {8'h00, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL clr_over_load: got a=%h wrap=%b b=%h want 00/0/00", a_cnt, a_wrap, b_cnt);
        end
        clr = 1'b0; load = 1'b0; enp = 1'b0; ent = 1'b0;
    endtask

    task automatic test_modulus();
        int exp_v;
        int wraps = 0;
        enp = 1'b1; ent = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            exp_v = (i + 1) % 10;
            if (b_wrap === 1'b1) wraps++;
            n_checks++;
            if ({b_cnt, b_wrap, b_rco} !== {8'(exp_v), (exp_v == 0), (exp_v == 9)}) begin
                n_fail++;
                $display("FAIL mod10[%0d]: got cnt=%h wrap=%b rco=%b want cnt=%h wrap=%b rco=%b",
                         i, b_cnt, b_wrap, b_rco, 8'(exp_v), (exp_v == 0), (exp_v == 9));
            end
        end
        n_checks++;
        if (wraps != 1) begin
            n_fail++;
            $display("FAIL mod10_wrap_count: got %0d pulses want 1", wraps);
        end
        enp = 1'b0; ent = 1'b0; load = 1'b1; load_val = 8'h0C;
        step();
        load = 1'b0; enp = 1'b1; ent = 1'b1;
        step();
        n_checks++;
        if ({b_cnt, b_wrap} !== {8'h0D, 1'b0}) begin
            n_fail++;
            $display("FAIL mod10_above_term: got cnt=%h wrap=%b want 0D/0", b_cnt, b_wrap);
        end
        enp = 1'b0; ent = 1'b0;
    endtask

    task automatic test_cascade();
        logic [3:0] prev0, prev1;
        c_clr = 1'b1;
        step();
        c_clr = 1'b0; c_enp = 1'b1; c_ent0 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            prev0 = c0_cnt;
            prev1 = c1_cnt;
            step();
            n_checks++;
            if ({c1_cnt, c0_cnt, c0_rco, c1_rco, c0_wrap, c1_wrap} !==
                {8'(mc_tot), (mc_tot % 16 == 15), (mc_tot == 255), mc_w0, mc_w1}) begin
                n_fail++;
                $display("FAIL cascade[%0d]: got %h%h rco=%b%b wrap=%b%b want %h rco=%b%b wrap=%b%b",
                         i, c1_cnt, c0_cnt, c1_rco, c0_rco, c1_wrap, c0_wrap, 8'(mc_tot),
                         (mc_tot == 255), (mc_tot % 16 == 15), mc_w1, mc_w0);
            end
            n_checks++;
            if ((c1_cnt != prev1) !== (prev0 == 4'hF)) begin
                n_fail++;
                $display("FAIL cascade_upper_step[%0d]: c1 %h->%h while c0 was %h", i, prev1, c1_cnt, prev0);
            end
        end
        n_checks++;
        if ({c1_cnt, c0_cnt} !== 8'h28) begin
            n_fail++;
            $display("FAIL cascade_total: got %h%h want 28", c1_cnt, c0_cnt);
        end
        c_enp = 1'b0; c_ent0 = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            rst  = ($urandom_range(63) == 0);
            clr  = ($urandom_range(31) == 0);
            load = ($urandom_range(4) == 0);
            case ($urandom_range(3))
                0:       load_val = 8'd3 + 8'($urandom_range(7));
                1:       load_val = 8'hF8 + 8'($urandom_range(7));
                default: load_val = 8'($urandom);
            endcase
            enp    = ($urandom_range(3) != 0);
            ent    = ($urandom_range(3) != 0);
            c_enp  = ($urandom_range(3) != 0);
            c_ent0 = ($urandom_range(3) != 0);
            c_clr  = ($urandom_range(63) == 0);
            step();
            n_checks++;
            if ({a_cnt, a_wrap, a_rco} !== {8'(ma_cnt), ma_wrap, (ent && ma_cnt == 255)}) begin
                n_fail++;
                $display("FAIL rand_a[%0d]: got cnt=%h wrap=%b rco=%b want cnt=%h wrap=%b rco=%b",
                         i, a_cnt, a_wrap, a_rco, 8'(ma_cnt), ma_wrap, (ent && ma_cnt == 255));
            end
            n_checks++;
            if ({b_cnt, b_wrap, b_rco} !== {8'(mb_cnt), mb_wrap, (ent && mb_cnt == 9)}) begin
                n_fail++;
                $display("FAIL rand_b[%0d]: got cnt=%h wrap=%b rco=%b want cnt=%h wrap=%b rco=%b",
                         i, b_cnt, b_wrap, b_rco, 8'(mb_cnt), mb_wrap, (ent && mb_cnt == 9));
            end
            n_checks++;
            if ({c1_cnt, c0_cnt, c0_rco, c1_rco, c0_wrap, c1_wrap} !==
                {8'(mc_tot), (c_ent0 && mc_tot % 16 == 15), (c_ent0 && mc_tot == 255), mc_w0, mc_w1}) begin
                n_fail++;
                $display("FAIL rand_casc[%0d]: got %h%h rco=%b%b wrap=%b%b want %h wrap=%b%b",
                         i, c1_cnt, c0_cnt, c1_rco, c0_rco, c1_wrap, c0_wrap, 8'(mc_tot), mc_w1, mc_w0);
            end
        end
        rst = 1'b0; clr = 1'b0; load = 1'b0; enp = 1'b0; ent = 1'b0;
        c_enp = 1'b0; c_ent0 = 1'b0; c_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; load = 1'b0; load_val = 8'h00; enp = 1'b0; ent = 1'b0;
        c_enp = 1'b0; c_ent0 = 1'b0; c_clr = 1'b0; c_load = 1'b0; c_lv = 4'h0;
        @(negedge clk);
        test_reset();
        test_count_wrap();
        test_enable_split();
        test_priority();
        test_modulus();
        test_cascade();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_sync_up_counter_casc

// File: doc/sync_up_counter_casc.md
Name: sync_up_counter_casc

Overview:
- Cascadable, synchronous, loadable binary up-counter.
- Complements the existing combinational down-count/load next-state slice: counts in the opposite direction and registers its own state.
- Built from chained 4-bit slices with an explicit carry chain.
- Used as a prescaler/event counter in the power-aware synthesis training set, and for equivalence checks against the down-count slice.

Parameters:
- WIDTH, 8, counter width in bits; must be a multiple of 4 and at least 4.
- TERM, 2**WIDTH-1, terminal count; the counter wraps to 0 after TERM; must satisfy 0 < TERM <= 2**WIDTH-1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous clear to 0; lower priority than rst.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value captured on load.
- enp  in  1  count enable, parallel; does not gate rco.
- ent  in  1  count enable, trickle; gates rco; cascade input.
- cnt  out  WIDTH  registered count value.
- rco  out  1  ripple carry out = ent & (cnt == TERM); combinational from registered cnt and ent.
- wrap  out  1  registered one-cycle pulse, asserted the cycle after a TERM->0 increment.

Behaviour:
- Reset values: cnt = 0, wrap = 0; rco = 0 while cnt == 0 (TERM > 0).
- Priority per rising edge, highest first:
  - rst: cnt <= 0, wrap <= 0.
  - clr: cnt <= 0, wrap <= 0.
  - load: cnt <= load_val, wrap <= 0.
  - enp & ent: increment.
  - otherwise: hold, wrap <= 0.
- Increment: if cnt == TERM, then cnt <= 0 and wrap <= 1; else cnt <= cnt + 1 and wrap <= 0.
- Arithmetic is modulo TERM+1.
- load_val > TERM: load it as-is. The next increment then proceeds with unsigned WIDTH-bit arithmetic and wraps naturally at 2**WIDTH-1 -> 0. wrap pulses only on the TERM->0 transition.
- Latency: cnt changes one cycle after the qualifying edge. rco reflects the new cnt in the same cycle (no extra register).
- load with enp & ent both high: load wins, no increment.
- clr and load asserted together: clr wins.
- Reset mid-count: state is discarded next edge; no partial slice update.
- Cascading: external chaining connects rco of a lower instance to ent of the next; enp is shared. TERM must be 2**WIDTH-1 for correct binary cascading (documented constraint, not checked).
- Internal carry: slice k increments when enp & ent & all lower slices are at their maximum, or when the internal wrap condition holds. Slice carry-out is purely combinational. No combinational path from load/clr to cnt.
- No X on outputs after the first reset edge; inputs before the first reset are don't-care.

Decomposition:
- Package cnt_pkg:
  - localparam SLICE_W = 4.
  - Function terminal_hit(cnt, term).
  - Typedef for the priority-decoded operation enum: OP_RST, OP_CLR, OP_LOAD, OP_INC, OP_HOLD.
- Sub-module cnt_slice4:
  - Inputs: clk, rst, 4-bit load data, op, carry_in.
  - Outputs: registered 4-bit value, carry_out = carry_in & (value == 4'hF).
  - Instantiated WIDTH/4 times in a generate loop.
- Top level: priority decode, TERM comparison/wrap override, rco and wrap generation.

Test Plan:
- Reset: assert rst 2 cycles with load=1, load_val=8'hA5 -> cnt=0, wrap=0, rco=0 throughout; no load occurs.
- Count and wrap (TERM=255): load 8'hFD, then enp=ent=1 for 4 cycles:
  - cnt = FD, FE, FF, 00, 01.
  - rco=1 only while cnt=FF.
  - wrap=1 exactly in the cycle cnt shows 00.
- Enable split: cnt=8'hFF, enp=0, ent=1 -> cnt holds FF, rco=1. With ent=0 -> rco=0 and cnt still holds.
- Priority: cnt=8'h10 with load=1, load_val=8'h3C, enp=ent=1 -> cnt=3C. Next cycle add clr=1 with load=1 -> cnt=00.
- Modulus (TERM=9): count from 0 with enable for 12 cycles -> 1..9,0,1,2; wrap pulses once, in the cycle cnt returns to 0. Load 8'h0C then increment -> 0D, no wrap.
- Cascade: two WIDTH=4 instances, rco0 -> ent1, shared enp, 40 enabled cycles from 0 -> combined {cnt1,cnt0} = 8'h28. cnt1 increments only on the edges where cnt0 goes F->0.
